// File: rtl/rdma_read_engine.sv
// AXI4 read-DMA master: fetches a byte range with INCR bursts into a stream FIFO and
// emits it as AXI4-Stream. Optional RRESP/RLAST checking enabled by RDMA_ERR_CHECK_EN.
module rdma_read_engine #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MAX_BURST  = 16,
  parameter int unsigned FIFO_DEPTH = 32
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic                  ap_start,
  output logic                  ap_ready,
  output logic                  ap_done,
  output logic                  ap_idle,
  input  logic [31:0]           rdma_transfer_byte,
  input  logic [ADDR_WIDTH-1:0] rdma_mem_ptr,
  output logic [ADDR_WIDTH-1:0] M_AXI_ARADDR,
  output logic [7:0]            M_AXI_ARLEN,
  output logic [2:0]            M_AXI_ARSIZE,
  output logic [1:0]            M_AXI_ARBURST,
  output logic                  M_AXI_ARVALID,
  input  logic                  M_AXI_ARREADY,
  input  logic [DATA_WIDTH-1:0] M_AXI_RDATA,
  input  logic [1:0]            M_AXI_RRESP,
  input  logic                  M_AXI_RLAST,
  input  logic                  M_AXI_RVALID,
  output logic                  M_AXI_RREADY,
  output logic [DATA_WIDTH-1:0] M_AXIS_TDATA,
  output logic                  M_AXIS_TVALID,
  input  logic                  M_AXIS_TREADY,
  output logic                  M_AXIS_TLAST,
  output logic                  rdma_err
);

  localparam int unsigned BYTES = DATA_WIDTH / 8;
  localparam int unsigned SIZE  = $clog2(BYTES);
  localparam int unsigned ALIGN = $clog2(MAX_BURST * BYTES);
  localparam int unsigned PW    = $clog2(FIFO_DEPTH);
  localparam int unsigned CW    = PW + 1;

  typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_DRAIN, S_DONE} state_t;

  state_t                r_state, w_next;
  logic                  r_ap_ready, r_ap_done, r_ap_idle;
  logic                  r_arvalid, r_rready;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [7:0]            r_arlen;
  logic [31:0]           r_rem, r_total, r_out_idx;
  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [PW-1:0]         r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]         r_count;
  logic                  r_tvalid, r_tlast;
  logic [DATA_WIDTH-1:0] r_tdata;

  logic                  w_start, w_ar_hs, w_r_hs, w_last_hs, w_push, w_pop, w_last_burst;
  logic [31:0]           w_beats, w_idx_nxt;
  logic [8:0]            w_burst;
  logic [CW-1:0]         w_free, w_cnt_nxt;
  logic [PW-1:0]         w_rd_nxt;
  logic [ADDR_WIDTH-1:0] w_aligned;
  logic                  w_unused;

  assign w_start      = (r_state == S_IDLE) && ap_start;
  assign w_ar_hs      = r_arvalid && M_AXI_ARREADY;
  assign w_r_hs       = M_AXI_RVALID && r_rready;
  assign w_last_hs    = w_r_hs && M_AXI_RLAST;
  assign w_push       = w_r_hs;
  assign w_pop        = r_tvalid && M_AXIS_TREADY;
  assign w_beats      = rdma_transfer_byte >> SIZE;
  assign w_aligned    = {rdma_mem_ptr[ADDR_WIDTH-1:ALIGN], {ALIGN{1'b0}}};
  assign w_burst      = (r_rem >= 32'(MAX_BURST)) ? 9'(MAX_BURST) : 9'(r_rem);
  assign w_free       = CW'(FIFO_DEPTH) - r_count;
  assign w_last_burst = (r_rem == (32'(r_arlen) + 32'd1));
  assign w_cnt_nxt    = r_count + CW'(w_push) - CW'(w_pop);
  assign w_rd_nxt     = r_rd_ptr + PW'(w_pop);
  assign w_idx_nxt    = r_out_idx + 32'(w_pop);

  always_ff @(posedge ACLK) begin
    if (ARESET) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (ap_start) w_next = (w_beats == 32'd0) ? S_DONE : S_AR;
      S_AR:    if (w_ar_hs) w_next = S_R;
      S_R:     if (w_last_hs) w_next = w_last_burst ? S_DRAIN : S_AR;
      S_DRAIN: if (r_count == '0) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Control handshakes, burst address/length bookkeeping
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_ap_ready <= 1'b0;
      r_ap_done  <= 1'b0;
      r_ap_idle  <= 1'b1;
      r_arvalid  <= 1'b0;
      r_rready   <= 1'b0;
      r_addr     <= '0;
      r_arlen    <= '0;
      r_rem      <= '0;
      r_total    <= '0;
    end else begin
      r_ap_ready <= w_start;
      r_ap_done  <= (r_state == S_DONE);
      r_ap_idle  <= (w_next == S_IDLE);
      if (w_start) begin
        r_addr  <= w_aligned;
        r_rem   <= w_beats;
        r_total <= w_beats;
      end
      // Issue only when the whole burst is guaranteed to fit in the FIFO
      if ((r_state == S_AR) && !r_arvalid && (32'(w_free) >= 32'(w_burst))) begin
        r_arvalid <= 1'b1;
        r_arlen   <= 8'(w_burst - 9'd1);
      end else if (w_ar_hs) begin
        r_arvalid <= 1'b0;
      end
      if (w_ar_hs)        r_rready <= 1'b1;
      else if (w_last_hs) r_rready <= 1'b0;
      if (w_last_hs) begin
        r_addr <= r_addr + ((ADDR_WIDTH'(r_arlen) + ADDR_WIDTH'(1)) << SIZE);
        r_rem  <= r_rem - (32'(r_arlen) + 32'd1);
      end
    end
  end

  always_ff @(posedge ACLK) begin
    if (w_push) r_mem[r_wr_ptr] <= M_AXI_RDATA;
  end

  // FIFO pointers and registered stream head; bypass when the pushed beat becomes the head
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_out_idx <= '0;
      r_tvalid  <= 1'b0;
      r_tlast   <= 1'b0;
      r_tdata   <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      r_rd_ptr  <= w_rd_nxt;
      r_count   <= w_cnt_nxt;
      r_out_idx <= w_start ? 32'd0 : w_idx_nxt;
      r_tvalid  <= (w_cnt_nxt != '0);
      r_tlast   <= (w_cnt_nxt != '0) && (w_idx_nxt == (r_total - 32'd1));
      r_tdata   <= (w_push && (w_cnt_nxt == CW'(1))) ? M_AXI_RDATA : r_mem[w_rd_nxt];
    end
  end

`ifdef RDMA_ERR_CHECK_EN
  logic [8:0] r_beat;
  logic       r_err;

  // Sticky error on bad response or RLAST not matching the requested length
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_err  <= 1'b0;
      r_beat <= '0;
    end else begin
      if (w_start) r_err <= 1'b0;
      else if (w_r_hs && ((M_AXI_RRESP != 2'b00) ||
                          (M_AXI_RLAST != (r_beat == 9'(r_arlen)))))
        r_err <= 1'b1;
      if (w_ar_hs)     r_beat <= '0;
      else if (w_r_hs) r_beat <= r_beat + 9'd1;
    end
  end

  assign rdma_err = r_err;
  assign w_unused = ^rdma_mem_ptr[ALIGN-1:0];
`else
  assign rdma_err = 1'b0;
  assign w_unused = ^{M_AXI_RRESP, rdma_mem_ptr[ALIGN-1:0]};
`endif

  assign ap_ready      = r_ap_ready;
  assign ap_done       = r_ap_done;
  assign ap_idle       = r_ap_idle;
  assign M_AXI_ARADDR  = r_addr;
  assign M_AXI_ARLEN   = r_arlen;
  assign M_AXI_ARSIZE  = 3'(SIZE);
  assign M_AXI_ARBURST = 2'b01;
  assign M_AXI_ARVALID = r_arvalid;
  assign M_AXI_RREADY  = r_rready;
  assign M_AXIS_TDATA  = r_tdata;
  assign M_AXIS_TVALID = r_tvalid;
  assign M_AXIS_TLAST  = r_tlast;

endmodule

// File: tb/tb_rdma_read_engine.sv
// Self-checking bench for rdma_read_engine: AXI slave memory model, stream sink and
// scoreboard queues of expected AR requests and stream beats.
module tb_rdma_read_engine;

  typedef struct {logic [31:0] addr; logic [7:0] len;} ar_t;
  typedef struct {logic [31:0] data; logic last;} beat_t;

  logic        ACLK = 1'b0;
  logic        ARESET = 1'b1;
  logic        ap_start = 1'b0;
  logic        ap_ready, ap_done, ap_idle;
  logic [31:0] rdma_transfer_byte = '0;
  logic [31:0] rdma_mem_ptr = '0;
  logic [31:0] M_AXI_ARADDR;
  logic [7:0]  M_AXI_ARLEN;
  logic [2:0]  M_AXI_ARSIZE;
  logic [1:0]  M_AXI_ARBURST;
  logic        M_AXI_ARVALID;
  logic        M_AXI_ARREADY = 1'b0;
  logic [31:0] M_AXI_RDATA = '0;
  logic [1:0]  M_AXI_RRESP = '0;
  logic        M_AXI_RLAST = 1'b0;
  logic        M_AXI_RVALID = 1'b0;
  logic        M_AXI_RREADY;
  logic [31:0] M_AXIS_TDATA;
  logic        M_AXIS_TVALID;
  logic        M_AXIS_TREADY = 1'b0;
  logic        M_AXIS_TLAST;
  logic        rdma_err;

`ifdef RDMA_ERR_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  ar_t   exp_ar[$];
  beat_t exp_s[$];
  ar_t   pend[$];

  int errors = 0, checks = 0;
  int cyc = 0, ready_cnt = 0, done_cnt = 0, ready_cyc = 0, done_cyc = 0;
  int ar_cnt = 0, arv_seen = 0, rbeats = 0, sbeats = 0;
  int tready_mode = 1;
  bit rand_slave = 1'b0;
  int inject_beat = -1;
  bit s_active = 1'b0, rv_hold = 1'b0;
  logic [31:0] s_addr = '0;
  int s_left = 0;

  rdma_read_engine dut (
    .ACLK(ACLK), .ARESET(ARESET), .ap_start(ap_start), .ap_ready(ap_ready),
    .ap_done(ap_done), .ap_idle(ap_idle), .rdma_transfer_byte(rdma_transfer_byte),
    .rdma_mem_ptr(rdma_mem_ptr), .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARLEN(M_AXI_ARLEN),
    .M_AXI_ARSIZE(M_AXI_ARSIZE), .M_AXI_ARBURST(M_AXI_ARBURST),
    .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
    .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP), .M_AXI_RLAST(M_AXI_RLAST),
    .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY),
    .M_AXIS_TDATA(M_AXIS_TDATA), .M_AXIS_TVALID(M_AXIS_TVALID),
    .M_AXIS_TREADY(M_AXIS_TREADY), .M_AXIS_TLAST(M_AXIS_TLAST), .rdma_err(rdma_err)
  );

  always #5 ACLK = ~ACLK;

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
  endfunction

  // Slave memory, stream sink and scoreboard; drives and samples on the falling edge
  initial begin : bus
    ar_t   p, e;
    beat_t b;
    forever begin
      @(negedge ACLK);
      cyc++;
      if (ARESET) begin
        M_AXI_ARREADY = 1'b0;
        M_AXI_RVALID  = 1'b0;
        M_AXI_RLAST   = 1'b0;
        M_AXIS_TREADY = 1'b0;
        rv_hold       = 1'b0;
      end else begin
        M_AXI_ARREADY = rand_slave ? 1'($urandom_range(0, 1)) : 1'b1;
        if (!s_active && pend.size() > 0) begin
          p        = pend.pop_front();
          s_active = 1'b1;
          s_addr   = p.addr;
          s_left   = int'(p.len) + 1;
        end
        if (s_active) begin
          if (!rv_hold) M_AXI_RVALID = rand_slave ? 1'($urandom_range(0, 1)) : 1'b1;
          M_AXI_RDATA = mem_f(s_addr);
          M_AXI_RLAST = (s_left == 1);
          M_AXI_RRESP = (rbeats == inject_beat) ? 2'b10 : 2'b00;
        end else begin
          M_AXI_RVALID = 1'b0;
          M_AXI_RLAST  = 1'b0;
          M_AXI_RRESP  = 2'b00;
        end
        M_AXIS_TREADY = (tready_mode == 0) ? 1'b0 :
                        (tready_mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));

        if (M_AXI_ARVALID) arv_seen++;
        if (M_AXI_ARVALID && M_AXI_ARREADY) begin
          ar_cnt++;
          checks++;
          if (exp_ar.size() == 0) begin
            errors++;
            $display("FAIL ar_unexpected got addr=%h len=%0d exp none", M_AXI_ARADDR, M_AXI_ARLEN);
          end else begin
            e = exp_ar.pop_front();
            if (M_AXI_ARADDR !== e.addr || M_AXI_ARLEN !== e.len ||
                M_AXI_ARSIZE !== 3'd2 || M_AXI_ARBURST !== 2'b01) begin
              errors++;
              $display("FAIL ar_req got addr=%h len=%0d size=%0d burst=%0d exp addr=%h len=%0d size=2 burst=1",
                       M_AXI_ARADDR, M_AXI_ARLEN, M_AXI_ARSIZE, M_AXI_ARBURST, e.addr, e.len);
            end
          end
          pend.push_back('{M_AXI_ARADDR, M_AXI_ARLEN});
        end
        rv_hold = M_AXI_RVALID && !M_AXI_RREADY;
        if (M_AXI_RVALID && M_AXI_RREADY) begin
          rbeats++;
          s_addr = s_addr + 32'd4;
          s_left--;
          if (s_left == 0) s_active = 1'b0;
        end
        if (M_AXIS_TVALID && M_AXIS_TREADY) begin
          sbeats++;
          checks++;
          if (exp_s.size() == 0) begin
            errors++;
            $display("FAIL stream_unexpected got data=%h last=%b exp none", M_AXIS_TDATA, M_AXIS_TLAST);
          end else begin
            b = exp_s.pop_front();
            if (M_AXIS_TDATA !== b.data || M_AXIS_TLAST !== b.last) begin
              errors++;
              $display("FAIL stream_beat%0d got data=%h last=%b exp data=%h last=%b",
                       sbeats, M_AXIS_TDATA, M_AXIS_TLAST, b.data, b.last);
            end
          end
        end
        if (ap_ready) begin
          ready_cnt++;
          ready_cyc = cyc;
        end
        if (ap_done) begin
          done_cnt++;
          done_cyc = cyc;
          checks++;
          if (exp_s.size() != 0) begin
            errors++;
            $display("FAIL done_early got beats_left=%0d exp 0", exp_s.size());
          end
        end
      end
    end
  end

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge ACLK);
      #1;
    end
  endtask

  task automatic clr_counters();
    ready_cnt = 0; done_cnt = 0; ar_cnt = 0; arv_seen = 0; sbeats = 0;
  endtask

  task automatic start_xfer(input int bytes, input logic [31:0] ptr, output bit ok);
    int total, rem, n;
    logic [31:0] a, al;
    total = bytes / 4;
    al    = ptr & 32'hFFFF_FFC0;
    a     = al;
    rem   = total;
    while (rem > 0) begin
      n = (rem > 16) ? 16 : rem;
      exp_ar.push_back('{a, 8'(n - 1)});
      a   = a + 32'(n * 4);
      rem = rem - n;
    end
    for (int i = 0; i < total; i++) exp_s.push_back('{mem_f(al + 32'(4 * i)), (i == total - 1)});
    rbeats             = 0;
    rdma_transfer_byte = 32'(bytes);
    rdma_mem_ptr       = ptr;
    ap_start           = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(posedge ACLK);
      #1;
      if (ap_ready) ok = 1'b1;
    end
    ap_start = 1'b0;
  endtask

  task automatic wait_done(input int target, input int max, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < max && !ok; k++) begin
      @(posedge ACLK);
      #1;
      if (done_cnt >= target) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    ARESET = 1'b1;
    tick(3);
    checks++;
    if ({ap_ready, ap_done, ap_idle, M_AXI_ARVALID, M_AXI_RREADY, M_AXIS_TVALID,
         M_AXIS_TLAST, rdma_err} !== 8'b0010_0000) begin
      errors++;
      $display("FAIL reset_outputs got %b exp 00100000", {ap_ready, ap_done, ap_idle,
               M_AXI_ARVALID, M_AXI_RREADY, M_AXIS_TVALID, M_AXIS_TLAST, rdma_err});
    end
    ARESET = 1'b0;
    tick(2);
  endtask

  task automatic test_single_burst(input string tag);
    bit ok;
    clr_counters();
    tready_mode = 1;
    start_xfer(64, 32'h1000, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL %s_ready_timeout got 0 exp 1", tag); end
    wait_done(1, 500, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL %s_done_timeout got 0 exp 1", tag); end
    tick(3);
    checks++;
    if (ar_cnt !== 1 || sbeats !== 16) begin
      errors++;
      $display("FAIL %s_counts got ar=%0d beats=%0d exp ar=1 beats=16", tag, ar_cnt, sbeats);
    end
    checks++;
    if (ready_cnt !== 1 || done_cnt !== 1 || ap_idle !== 1'b1) begin
      errors++;
      $display("FAIL %s_pulses got ready=%0d done=%0d idle=%b exp 1 1 1", tag, ready_cnt, done_cnt, ap_idle);
    end
  endtask

  task automatic test_remainder();
    bit ok;
    clr_counters();
    start_xfer(100, 32'h1000, ok);
    wait_done(1, 500, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL rem_done_timeout got 0 exp 1"); end
    tick(2);
    checks++;
    if (ar_cnt !== 2 || sbeats !== 25 || exp_ar.size() != 0) begin
      errors++;
      $display("FAIL rem_counts got ar=%0d beats=%0d ar_left=%0d exp 2 25 0", ar_cnt, sbeats, exp_ar.size());
    end
  endtask

  task automatic test_zero_bytes();
    bit ok;
    clr_counters();
    start_xfer(0, 32'h1000, ok);
    wait_done(1, 20, ok);
    tick(5);
    checks++;
    if (!ok || done_cyc !== ready_cyc + 1) begin
      errors++;
      $display("FAIL zero_done_latency got ready_cyc=%0d done_cyc=%0d exp done=ready+1", ready_cyc, done_cyc);
    end
    checks++;
    if (arv_seen !== 0 || sbeats !== 0 || done_cnt !== 1) begin
      errors++;
      $display("FAIL zero_no_traffic got arvalid_cycles=%0d beats=%0d done=%0d exp 0 0 1", arv_seen, sbeats, done_cnt);
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    clr_counters();
    tready_mode = 0;
    start_xfer(256, 32'h2000, ok);
    tick(150);
    checks++;
    if (ar_cnt !== 2 || M_AXI_ARVALID !== 1'b0 || sbeats !== 0 || M_AXIS_TVALID !== 1'b1) begin
      errors++;
      $display("FAIL bp_stall got ar=%0d arvalid=%b beats=%0d tvalid=%b exp 2 0 0 1",
               ar_cnt, M_AXI_ARVALID, sbeats, M_AXIS_TVALID);
    end
    tready_mode = 1;
    wait_done(1, 1000, ok);
    tick(2);
    checks++;
    if (!ok || ar_cnt !== 4 || sbeats !== 64) begin
      errors++;
      $display("FAIL bp_release got done=%b ar=%0d beats=%0d exp 1 4 64", ok, ar_cnt, sbeats);
    end
  endtask

  task automatic test_reset_mid_burst();
    bit ok;
    clr_counters();
    tready_mode = 0;
    start_xfer(64, 32'h1000, ok);
    ok = 1'b0;
    for (int k = 0; k < 100 && !ok; k++) begin
      tick(1);
      if (rbeats >= 4) ok = 1'b1;
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL midrst_reach_r got rbeats=%0d exp >=4", rbeats); end
    ARESET = 1'b1;
    tick(1);
    checks++;
    if (M_AXI_ARVALID !== 1'b0 || M_AXIS_TVALID !== 1'b0 || M_AXI_RREADY !== 1'b0 || ap_idle !== 1'b1) begin
      errors++;
      $display("FAIL midrst_outputs got arvalid=%b tvalid=%b rready=%b idle=%b exp 0 0 0 1",
               M_AXI_ARVALID, M_AXIS_TVALID, M_AXI_RREADY, ap_idle);
    end
    ARESET = 1'b0;
    exp_ar.delete();
    exp_s.delete();
    pend.delete();
    s_active = 1'b0;
    rv_hold  = 1'b0;
    tready_mode = 1;
    tick(10);
    checks++;
    if (done_cnt !== 0 || M_AXIS_TVALID !== 1'b0) begin
      errors++;
      $display("FAIL midrst_no_done got done=%0d tvalid=%b exp 0 0", done_cnt, M_AXIS_TVALID);
    end
    test_single_burst("after_rst");
  endtask

  task automatic test_err();
    bit ok;
    clr_counters();
    inject_beat = 2;
    start_xfer(64, 32'h3000, ok);
    wait_done(1, 500, ok);
    tick(2);
    checks++;
    if (!ok || rdma_err !== EXP_ERR) begin
      errors++;
      $display("FAIL err_sticky got done=%b err=%b exp 1 %b", ok, rdma_err, EXP_ERR);
    end
    inject_beat = -1;
    start_xfer(64, 32'h3000, ok);
    checks++;
    if (!ok || rdma_err !== 1'b0) begin
      errors++;
      $display("FAIL err_clear got ready=%b err=%b exp 1 0", ok, rdma_err);
    end
    wait_done(2, 500, ok);
    tick(2);
    checks++;
    if (!ok || rdma_err !== 1'b0) begin
      errors++;
      $display("FAIL err_clean_run got done=%b err=%b exp 1 0", ok, rdma_err);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int bytes;
    logic [31:0] ptr;
    rand_slave  = 1'b1;
    tready_mode = 2;
    for (int t = 0; t < 5; t++) begin
      clr_counters();
      bytes = $urandom_range(4, 400);
      ptr   = $urandom;
      start_xfer(bytes, ptr, ok);
      wait_done(1, 5000, ok);
      checks++;
      if (!ok || exp_s.size() != 0 || exp_ar.size() != 0 || sbeats !== bytes / 4) begin
        errors++;
        $display("FAIL b2b_%0d got done=%b beats=%0d beats_left=%0d ar_left=%0d exp 1 %0d 0 0",
                 t, ok, sbeats, exp_s.size(), exp_ar.size(), bytes / 4);
      end
    end
    rand_slave  = 1'b0;
    tready_mode = 1;
  endtask

  initial begin
    test_reset();
    test_single_burst("single");
    test_remainder();
    test_zero_bytes();
    test_backpressure();
    test_reset_mid_burst();
    test_err();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog expired");
  end

endmodule
